// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared requester IDs and FSM encoding for the memory port arbiter
package mem_arb_pkg;

  localparam logic [1:0] ID_FETCH = 2'd0;
  localparam logic [1:0] ID_DATA  = 2'd1;
  localparam logic [1:0] ID_LOAD  = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fixed-priority winner select with fetch starvation guard
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       f_req,
  input  logic       d_req,
  input  logic       l_req,
  input  logic       grant,
  output logic [1:0] winner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          fetch_urgent;

  assign fetch_urgent = (starve_cnt == CW'(STARVE_LIMIT));

  // Loader always wins; a starved fetch only overtakes data.
  always_comb begin
    winner = ID_NONE;
    if (l_req)
      winner = ID_LOAD;
    else if (d_req && !(f_req && fetch_urgent))
      winner = ID_DATA;
    else if (f_req)
      winner = ID_FETCH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (f_req && winner != ID_FETCH) begin
        if (!fetch_urgent)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port main memory between fetch, data and loader
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        grant_id
);

  arb_state_t state;
  logic [1:0] lat_cnt;
  logic [1:0] lat_last;
  logic [1:0] winner;
  logic       cur_we;
  logic       grant;

  assign grant = (state == ST_IDLE) && (f_req || d_req || l_req);
  assign busy  = (state != ST_IDLE);

  // WAIT holds one settle cycle beyond the memory latency: writes stay one
  // cycle, reads capture mem_q on the second-to-last WAIT edge.
  assign lat_last = cur_we ? 2'd0 : 2'(READ_LATENCY);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clock (clock),
    .reset (reset),
    .f_req (f_req),
    .d_req (d_req),
    .l_req (l_req),
    .grant (grant),
    .winner(winner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      l_ack       <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      rdata       <= '0;
      grant_id    <= ID_NONE;
      lat_cnt     <= '0;
      cur_we      <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      l_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            grant_id <= winner;
            state    <= ST_ACCESS;
            case (winner)
              ID_LOAD: begin
                mem_address <= l_addr;
                mem_data    <= l_wdata;
                mem_wren    <= l_we;
                cur_we      <= l_we;
              end
              ID_DATA: begin
                mem_address <= d_addr;
                mem_data    <= d_wdata;
                mem_wren    <= d_we;
                cur_we      <= d_we;
              end
              default: begin
                mem_address <= f_addr;
                mem_wren    <= 1'b0;
                cur_we      <= 1'b0;
              end
            endcase
          end
        end
        ST_ACCESS: begin
          mem_wren <= 1'b0;
          lat_cnt  <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!cur_we && lat_cnt == 2'(READ_LATENCY - 1))
            rdata <= mem_q;
          if (lat_cnt == lat_last) begin
            state <= ST_RESP;
            case (grant_id)
              ID_LOAD: l_ack <= 1'b1;
              ID_DATA: d_ack <= 1'b1;
              default: f_ack <= 1'b1;
            endcase
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          grant_id <= ID_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int RL     = 1;
  localparam int STARVE = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // instance A: READ_LATENCY 1, all requesters
  logic        rst_a, f_req, d_req, d_we, l_req, l_we;
  logic [15:0] f_addr, d_addr, d_wdata, l_addr, l_wdata;
  logic        f_ack, d_ack, l_ack, busy, mem_wren;
  logic [15:0] rdata, mem_address, mem_data, mem_q;
  logic [1:0]  grant_id;

  // instances B (READ_LATENCY 2) and C (READ_LATENCY 3): fetch only
  logic        zero1;
  logic [15:0] zero16;
  logic        rst_b, f_req_b, f_ack_b, d_ack_b, l_ack_b, busy_b, mem_wren_b;
  logic        rst_c, f_req_c, f_ack_c, d_ack_c, l_ack_c, busy_c, mem_wren_c;
  logic [15:0] f_addr_b, rdata_b, mem_address_b, mem_data_b, mem_q_b;
  logic [15:0] f_addr_c, rdata_c, mem_address_c, mem_data_c, mem_q_c;
  logic [1:0]  grant_id_b, grant_id_c;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .READ_LATENCY(RL), .STARVE_LIMIT(STARVE)) u_dut (
    .clock(clock), .reset(rst_a),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .READ_LATENCY(2), .STARVE_LIMIT(STARVE)) u_dut_b (
    .clock(clock), .reset(rst_b),
    .f_req(f_req_b), .f_addr(f_addr_b), .f_ack(f_ack_b),
    .d_req(zero1), .d_we(zero1), .d_addr(zero16), .d_wdata(zero16), .d_ack(d_ack_b),
    .l_req(zero1), .l_we(zero1), .l_addr(zero16), .l_wdata(zero16), .l_ack(l_ack_b),
    .rdata(rdata_b), .mem_address(mem_address_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b),
    .mem_q(mem_q_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .READ_LATENCY(3), .STARVE_LIMIT(STARVE)) u_dut_c (
    .clock(clock), .reset(rst_c),
    .f_req(f_req_c), .f_addr(f_addr_c), .f_ack(f_ack_c),
    .d_req(zero1), .d_we(zero1), .d_addr(zero16), .d_wdata(zero16), .d_ack(d_ack_c),
    .l_req(zero1), .l_we(zero1), .l_addr(zero16), .l_wdata(zero16), .l_ack(l_ack_c),
    .rdata(rdata_c), .mem_address(mem_address_c), .mem_data(mem_data_c), .mem_wren(mem_wren_c),
    .mem_q(mem_q_c), .busy(busy_c), .grant_id(grant_id_c)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hABCD : {a ^ 8'h5A, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory A: single port, write on edge, read data valid one edge later
  logic [15:0]  mem_a [256];
  logic [255:0] wrote_a;
  always @(posedge clock) begin
    if (!rst_a)
      wrote_a <= '0;
    else if (mem_wren) begin
      mem_a[mem_address[7:0]]   <= mem_data;
      wrote_a[mem_address[7:0]] <= 1'b1;
    end
    mem_q <= wrote_a[mem_address[7:0]] ? mem_a[mem_address[7:0]] : init_val(mem_address[7:0]);
  end

  // memories B/C: word tags the edge index that sampled it, delayed RL edges
  logic [15:0] sb0, sb1, sc0, sc1, sc2;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    sb0 <= {cyc[7:0], mem_address_b[7:0]};
    sb1 <= sb0;
    sc0 <= {cyc[7:0], mem_address_c[7:0]};
    sc1 <= sc0;
    sc2 <= sc1;
  end
  assign mem_q_b = sb1;
  assign mem_q_c = sc2;

  // transaction-level model of instance A
  logic        m_active, m_we;
  logic [1:0]  m_owner;
  logic [15:0] m_addr, m_wdata, exp_rdata;
  int          m_t, m_lat, m_starve;
  logic [15:0] ref_mem [256];
  int          grants [$];

  initial begin : model
    m_active = 1'b0; m_t = 0; m_lat = 0; m_starve = 0; m_owner = 2'd3;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; exp_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    forever begin
      @(posedge clock);
      if (!rst_a) begin
        m_active = 1'b0; m_starve = 0; exp_rdata = '0; m_owner = 2'd3;
      end else begin
        if (m_active) begin
          m_t++;
          if (m_t == m_lat && !m_we) exp_rdata = ref_mem[m_addr[7:0]];
          if (m_t == m_lat + 2) m_active = 1'b0;
        end
        if (!m_active && (l_req || d_req || f_req)) begin
          if (l_req)                                       m_owner = 2'd2;
          else if (d_req && !(f_req && m_starve == STARVE)) m_owner = 2'd1;
          else                                             m_owner = 2'd0;
          if (f_req && m_owner != 2'd0) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
          else                          m_starve = 0;
          case (m_owner)
            2'd2:    begin m_we = l_we; m_addr = l_addr; m_wdata = l_wdata; end
            2'd1:    begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
            default: begin m_we = 1'b0; m_addr = f_addr; m_wdata = mem_data; end
          endcase
          if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
          m_lat    = m_we ? 2 : 2 + RL;
          m_t      = 0;
          m_active = 1'b1;
          grants.push_back(int'(m_owner));
        end
      end
    end
  end

  initial begin : compare
    logic eb;
    forever begin
      @(negedge clock);
      if (rst_a) begin
        eb = m_active && (m_t <= m_lat);
        chk("busy", busy, eb);
        chk("grant_id", grant_id, eb ? m_owner : 2'd3);
        chk("f_ack", f_ack, m_active && m_t == m_lat && m_owner == 2'd0);
        chk("d_ack", d_ack, m_active && m_t == m_lat && m_owner == 2'd1);
        chk("l_ack", l_ack, m_active && m_t == m_lat && m_owner == 2'd2);
        chk("mem_wren", mem_wren, m_active && m_t == 0 && m_we);
        if (m_active && m_t == 0) begin
          chk("mem_address", mem_address, m_addr);
          if (m_we) chk("mem_data", mem_data, m_wdata);
        end
        if (!eb || m_t == m_lat) chk("rdata", rdata, exp_rdata);
      end
    end
  end

  task automatic do_req(input int who, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int edges);
    logic got;
    edges = 0;
    got   = 1'b0;
    case (who)
      0:       begin f_addr = addr; f_req = 1'b1; end
      1:       begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
      default: begin l_we = we; l_addr = addr; l_wdata = wdata; l_req = 1'b1; end
    endcase
    while (!got && edges < 60) begin
      @(negedge clock);
      edges++;
      case (who)
        0:       got = f_ack;
        1:       got = d_ack;
        default: got = l_ack;
      endcase
    end
    case (who)
      0:       f_req = 1'b0;
      1:       d_req = 1'b0;
      default: l_req = 1'b0;
    endcase
    chk("ack_within_bound", got, 1'b1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int e, e1, e2, e3, g, n0;
    int exp_g [6];
    logic [15:0] expv;
    logic got;
    rst_a = 0; rst_b = 0; rst_c = 0;
    zero1 = 0; zero16 = '0;
    f_req = 0; d_req = 0; l_req = 0; d_we = 0; l_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; l_addr = '0; l_wdata = '0;
    f_req_b = 0; f_addr_b = '0; f_req_c = 0; f_addr_c = '0;
    repeat (3) @(negedge clock);
    chk("rst_f_ack", f_ack, 0);       chk("rst_d_ack", d_ack, 0);
    chk("rst_l_ack", l_ack, 0);       chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 3);    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_address, 0);  chk("rst_data", mem_data, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_b_grant", grant_id_b, 3); chk("rst_c_busy", busy_c, 0);
    rst_a = 1; rst_b = 1; rst_c = 1;
    @(negedge clock);

    do_req(0, 1'b0, 16'h0010, 16'h0, e);
    chk("fetch_edges", e, 4);
    chk("fetch_rdata", rdata, 16'hABCD);
    @(negedge clock);
    do_req(1, 1'b1, 16'h0020, 16'h1234, e);
    chk("dwrite_edges", e, 3);
    chk("dwrite_keeps_rdata", rdata, 16'hABCD);
    do_req(0, 1'b0, 16'h0020, 16'h0, e);
    chk("readback", rdata, 16'h1234);

    @(negedge clock);
    n0 = grants.size();
    fork
      do_req(2, 1'b1, 16'h0030, 16'h7777, e1);
      begin do_req(1, 1'b0, 16'h0010, 16'h0, e2); chk("prio_d_rdata", rdata, 16'hABCD); end
      begin do_req(0, 1'b0, 16'h0030, 16'h0, e3); chk("prio_f_rdata", rdata, 16'h7777); end
    join
    chk("prio_l_edges", e1, 3);
    chk("prio_d_edges", e2, 8);
    chk("prio_f_edges", e3, 13);
    chk("prio_count", grants.size() - n0, 3);
    chk("prio_g0", grants[n0], 2);
    chk("prio_g1", grants[n0 + 1], 1);
    chk("prio_g2", grants[n0 + 2], 0);

    @(negedge clock);
    n0 = grants.size();
    fork
      do_req(0, 1'b0, 16'h0010, 16'h0, e3);
      begin
        for (int i = 0; i < 5; i++) do_req(1, 1'b1, 16'(16'h0050 + i), 16'(16'h0100 + i), e2);
      end
    join
    chk("starve_f_edges", e3, 20);
    chk("starve_count", grants.size() - n0, 6);
    exp_g = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) chk("starve_order", grants[n0 + i], exp_g[i]);

    @(negedge clock);
    d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555; d_req = 1'b1;
    @(negedge clock);
    d_req = 1'b0; d_addr = 16'h0041; d_wdata = 16'hFFFF;
    e = 1; got = 1'b0;
    while (!got && e < 10) begin @(negedge clock); e++; got = d_ack; end
    chk("viol_ack_edges", e, 3);
    do_req(0, 1'b0, 16'h0040, 16'h0, e);
    chk("viol_data", rdata, 16'h5555);
    do_req(0, 1'b0, 16'h0041, 16'h0, e);
    chk("viol_nowrite", rdata, init_val(8'h41));

    // READ_LATENCY 2: ack on 5th negedge, data sampled 2 edges after memory edge
    @(negedge clock);
    g = cyc; f_addr_b = 16'h0005; f_req_b = 1'b1; expv = {8'(g + 1), 8'h05};
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      chk("b_ack", f_ack_b, k == 5);
      if (f_ack_b) f_req_b = 1'b0;
    end
    f_req_b = 1'b0;
    chk("b_rdata", rdata_b, expv);

    // READ_LATENCY 3: one clean read, then reset in WAIT, then re-serve
    @(negedge clock);
    g = cyc; f_addr_c = 16'h0007; f_req_c = 1'b1; expv = {8'(g + 1), 8'h07};
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk("c_ack", f_ack_c, k == 6);
      if (f_ack_c) f_req_c = 1'b0;
    end
    f_req_c = 1'b0;
    chk("c_rdata", rdata_c, expv);
    @(negedge clock);
    f_addr_c = 16'h0009; f_req_c = 1'b1;
    repeat (3) @(negedge clock);
    #2 rst_c = 1'b0;
    #1;
    chk("c_rst_busy", busy_c, 0);    chk("c_rst_grant", grant_id_c, 3);
    chk("c_rst_rdata", rdata_c, 0);  chk("c_rst_ack", f_ack_c, 0);
    chk("c_rst_wren", mem_wren_c, 0); chk("c_rst_addr", mem_address_c, 0);
    repeat (2) begin @(negedge clock); chk("c_rst_hold_ack", f_ack_c, 0); end
    rst_c = 1'b1;
    g = cyc; expv = {8'(g + 1), 8'h09};
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk("c_reserve_ack", f_ack_c, k == 6);
      if (f_ack_c) f_req_c = 1'b0;
    end
    f_req_c = 1'b0;
    chk("c_reserve_rdata", rdata_c, expv);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
